// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: one-hot bit positions, alu_op classes,
// R-type func codes and the sequencing FSM states.
package alu_ctrl_pkg;

  localparam int NUM_OPS   = 15;

  localparam int BIT_ADD   = 0;
  localparam int BIT_SUB   = 1;
  localparam int BIT_AND   = 2;
  localparam int BIT_OR    = 3;
  localparam int BIT_XOR   = 4;
  localparam int BIT_NOR   = 5;
  localparam int BIT_SRA   = 6;
  localparam int BIT_SLT   = 7;
  localparam int BIT_SLL   = 8;
  localparam int BIT_SRL   = 9;
  localparam int BIT_SLTU  = 10;
  localparam int BIT_MULT  = 11;
  localparam int BIT_MULTU = 12;
  localparam int BIT_DIV   = 13;
  localparam int BIT_DIVU  = 14;

  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_SLT   = 6'b001000;
  localparam logic [5:0] OP_XOR   = 6'b010000;
  localparam logic [5:0] OP_SUB   = 6'b000000;
  localparam logic [5:0] OP_RTYPE = 6'b100000;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    MDW  = 2'd2
  } state_t;

  function automatic logic [NUM_OPS-1:0] onehot(input int idx);
    return NUM_OPS'(1) << idx;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of alu_op/func into the one-hot ALU control word plus
// jump-register, mul-div class and unmatched-encoding flags.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input  logic [5:0]        alu_op,
  input  logic [5:0]        func,
  output logic [CTRL_W-1:0] ctrl,
  output logic              jump_reg,
  output logic              is_md,
  output logic              is_mul,
  output logic              illegal_raw
);

  logic [NUM_OPS-1:0] word;

  always_comb begin
    word        = '0;
    jump_reg    = 1'b0;
    illegal_raw = 1'b0;
    case (alu_op)
      OP_ADD:   word = onehot(BIT_ADD);
      OP_AND:   word = onehot(BIT_AND);
      OP_OR:    word = onehot(BIT_OR);
      OP_SLT:   word = onehot(BIT_SLT);
      OP_XOR:   word = onehot(BIT_XOR);
      OP_SUB:   word = onehot(BIT_SUB);
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU: word = onehot(BIT_ADD);
          FN_SUB, FN_SUBU: word = onehot(BIT_SUB);
          FN_AND:   word = onehot(BIT_AND);
          FN_OR:    word = onehot(BIT_OR);
          FN_XOR:   word = onehot(BIT_XOR);
          FN_NOR:   word = onehot(BIT_NOR);
          FN_SLL:   word = onehot(BIT_SLL);
          FN_SRL:   word = onehot(BIT_SRL);
          FN_SRA:   word = onehot(BIT_SRA);
          FN_SLT:   word = onehot(BIT_SLT);
          FN_SLTU:  word = onehot(BIT_SLTU);
          FN_JR:    jump_reg = 1'b1;
          FN_MULT:  word = onehot(BIT_MULT);
          FN_MULTU: word = onehot(BIT_MULTU);
          FN_DIV:   word = onehot(BIT_DIV);
          FN_DIVU:  word = onehot(BIT_DIVU);
          default:  illegal_raw = 1'b1;
        endcase
      end
      default: illegal_raw = 1'b1;
    endcase
  end

  assign is_md  = |word[BIT_DIVU:BIT_MULT];
  assign is_mul = word[BIT_MULT] | word[BIT_MULTU];

  // Bits beyond the defined operations are tied low.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl
    if (gi < NUM_OPS) begin : g_op
      assign ctrl[gi] = word[gi];
    end else begin : g_tie
      assign ctrl[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Registered ALU control unit with valid/ready handshakes and MULT/DIV sequencing.
// Optional `illegal` output is enabled by defining ALU_CTRL_ILLEGAL_EN.
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        alu_op,
  input  logic [5:0]        func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              jump_reg,
  output logic              md_start,
  output logic              md_busy
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic              illegal
`endif
);

  localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_jr;
  logic              dec_md;
  logic              dec_mul;
  logic              dec_ill;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              jr_reg;
  logic              start_reg;
  logic              accept;

  alu_ctrl_dec #(
    .CTRL_W (CTRL_W)
  ) u_dec (
    .alu_op      (alu_op),
    .func        (func),
    .ctrl        (dec_ctrl),
    .jump_reg    (dec_jr),
    .is_md       (dec_md),
    .is_mul      (dec_mul),
    .illegal_raw (dec_ill)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    md_busy    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = dec_md ? MDW : OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Consuming and accepting in one cycle keeps back-to-back throughput.
        if (out_ready) state_next = in_valid ? (dec_md ? MDW : OUT) : IDLE;
      end
      MDW: begin
        md_busy = 1'b1;
        if (cnt_reg == '0) state_next = OUT;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ctrl_reg  <= '0;
      jr_reg    <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= accept && dec_md;
      if (accept) begin
        ctrl_reg <= dec_ctrl;
        jr_reg   <= dec_jr;
        cnt_reg  <= dec_md ? (dec_mul ? MUL_LOAD : DIV_LOAD) : '0;
      end else if (state_reg == MDW && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic ill_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_reg <= 1'b0;
    end else if (accept) begin
      ill_reg <= dec_ill;
    end
  end

  assign illegal = ill_reg;
`else
  logic unused_ill;
  assign unused_ill = dec_ill;
`endif

  assign alu_control = ctrl_reg;
  assign jump_reg    = jr_reg;
  assign md_start    = start_reg;

endmodule
